// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointing fe_queue FIFO: write, speculative-read and commit pointers.
// Issued entries stay resident until committed so a replay can rewind to them.
module bp_be_fe_queue_ckpt #(
  parameter int unsigned width_p      = 1,
  parameter int unsigned els_p        = 8,
  localparam int unsigned ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,
  input  logic               clr_i,
  input  logic               roll_i,
  input  logic               deq_i
);

  localparam int unsigned idx_width_lp = ptr_width_lp - 1;

  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] cptr_q, cptr_d;
  logic [width_p-1:0]      mem_q [els_p];

  logic [ptr_width_lp-1:0] occ, iss;
  logic                    full, enq, yumi_eff, deq_eff;

  // Occupancy counts every entry not yet committed, issued or not.
  assign occ      = wptr_q - cptr_q;
  assign iss      = rptr_q - cptr_q;
  assign full     = (occ == ptr_width_lp'(els_p));

  assign ready_o  = ~full;
  assign v_o      = (rptr_q != wptr_q);
  assign data_o   = mem_q[rptr_q[idx_width_lp-1:0]];

  assign enq      = v_i & ~full;
  assign yumi_eff = yumi_i & v_o;
  assign deq_eff  = deq_i & (cptr_q != rptr_q);

  // Commit lands first so a simultaneous roll rewinds to the new checkpoint;
  // clr then collapses the write pointer onto the resulting read pointer.
  always_comb begin
    cptr_d = cptr_q + ptr_width_lp'(deq_eff);
    rptr_d = roll_i ? cptr_d : rptr_q + ptr_width_lp'(yumi_eff);
    wptr_d = clr_i  ? rptr_d : wptr_q + ptr_width_lp'(enq);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // Storage is never reset; v_o masks stale contents.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q[idx_width_lp-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (occ <= ptr_width_lp'(els_p) && iss <= occ);
  end

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
// Bench for bp_be_fe_queue_ckpt: scenario tasks checked against a queue model
// holding uncommitted packets plus a count of how many have been issued.
module tb_bp_be_fe_queue_ckpt;
  localparam int W = 8;
  localparam int E = 8;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [W-1:0] data_i, data_o;
  logic         v_i, ready_o, v_o, yumi_i, clr_i, roll_i, deq_i;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mq[$];
  int           iss;

  always #5 clk_i = ~clk_i;

  bp_be_fe_queue_ckpt #(.width_p(W), .els_p(E)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .v_i(v_i),
    .ready_o(ready_o), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i),
    .clr_i(clr_i), .roll_i(roll_i), .deq_i(deq_i)
  );

  function automatic logic exp_v();
    return iss < mq.size();
  endfunction

  function automatic logic exp_rdy();
    return mq.size() < E;
  endfunction

  function automatic logic [W-1:0] exp_d();
    return (iss < mq.size()) ? mq[iss] : '0;
  endfunction

  function automatic void model_clear();
    mq.delete();
    iss = 0;
  endfunction

  // One clock: drive inputs, advance, update model from pre-edge state.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic y,
                     input logic c, input logic r, input logic dq);
    bit e_deq, e_y, e_enq;
    v_i = v; data_i = d; yumi_i = y; clr_i = c; roll_i = r; deq_i = dq;
    e_deq = dq && (iss > 0);
    e_y   = y && (iss < mq.size());
    e_enq = v && (mq.size() < E);
    @(posedge clk_i); #1;
    if (e_deq) begin mq.delete(0); iss--; end
    if (r) iss = 0;
    else if (e_y) iss++;
    if (c) begin
      while (mq.size() > iss) mq.delete(mq.size() - 1);
    end else if (e_enq) mq.push_back(d);
    v_i = 0; yumi_i = 0; clr_i = 0; roll_i = 0; deq_i = 0; data_i = '0;
  endtask

  task automatic do_reset(input bit busy);
    reset_i = 1'b1;
    v_i = busy; data_i = 8'hA5; yumi_i = busy; deq_i = busy; roll_i = 1'b0; clr_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    v_i = 0; yumi_i = 0; deq_i = 0; data_i = '0;
    model_clear();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    v_i = 0; data_i = '0; yumi_i = 0; clr_i = 0; roll_i = 0; deq_i = 0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    model_clear();
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v got %b exp 0", v_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
  endtask

  task automatic test_fill();
    do_reset(0);
    for (int i = 0; i < E; i++) begin
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b exp 1", i, ready_o); end
      cyc(1, W'(i), 0, 0, 0, 0);
    end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL fill_full got %b exp 0", ready_o); end
    cyc(1, 8'h99, 0, 0, 0, 0);
    checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL fill_v got %b exp 1", v_o); end
    checks++; if (data_o !== 8'd0) begin errors++; $display("FAIL fill_head got %h exp 00", data_o); end
    // Drain: the dropped 0x99 must never appear.
    for (int i = 0; i < E; i++) begin
      checks++;
      if (data_o !== W'(i) || v_o !== 1'b1) begin
        errors++; $display("FAIL fill_drain_%0d got %h/%b exp %h/1", i, data_o, v_o, W'(i));
      end
      cyc(0, 0, 1, 0, 0, 0);
    end
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL fill_empty got %b exp 0", v_o); end
  endtask

  task automatic test_replay();
    do_reset(0);
    for (int i = 0; i < E; i++) cyc(1, W'(i), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (data_o !== W'(i)) begin errors++; $display("FAIL replay_pre_%0d got %h exp %h", i, data_o, W'(i)); end
      cyc(0, 0, 1, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 1, 0);
    checks++; if (data_o !== 8'd0) begin errors++; $display("FAIL replay_roll got %h exp 00", data_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_o !== W'(i)) begin errors++; $display("FAIL replay_post_%0d got %h exp %h", i, data_o, W'(i)); end
      cyc(0, 0, 1, 0, 0, 0);
    end
  endtask

  task automatic test_commit_roll();
    do_reset(0);
    for (int i = 0; i < E; i++) cyc(1, W'(i), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL cr_ready got %b exp 1", ready_o); end
    cyc(0, 0, 0, 0, 1, 0);
    checks++; if (data_o !== 8'd2) begin errors++; $display("FAIL cr_roll got %h exp 02", data_o); end
    cyc(1, 8'd8, 0, 0, 0, 0);
    cyc(1, 8'd9, 0, 0, 0, 0);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL cr_refull got %b exp 0", ready_o); end
    for (int i = 0; i < E; i++) begin
      checks++;
      if (data_o !== W'(i + 2)) begin errors++; $display("FAIL cr_seq_%0d got %h exp %h", i, data_o, W'(i + 2)); end
      cyc(0, 0, 1, 0, 0, 0);
    end
  endtask

  task automatic test_clr();
    do_reset(0);
    for (int i = 0; i < 6; i++) cyc(1, W'(i), 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 8'h77, 0, 1, 0, 0);
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL clr_v got %b exp 0", v_o); end
    cyc(0, 0, 0, 0, 1, 0);
    checks++; if (v_o !== 1'b1 || data_o !== 8'd0) begin errors++; $display("FAIL clr_roll got %h/%b exp 00/1", data_o, v_o); end
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (data_o !== 8'd1) begin errors++; $display("FAIL clr_second got %h exp 01", data_o); end
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL clr_drained got %b exp 0", v_o); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] sent[$];
    int nyumi = 0;
    do_reset(0);
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL wrap_ready_%0d got %b exp 1", k, ready_o); end
      if (k >= 2) begin
        checks++;
        if (v_o !== 1'b1 || data_o !== sent[nyumi]) begin
          errors++; $display("FAIL wrap_data_%0d got %h/%b exp %h/1", k, data_o, v_o, sent[nyumi]);
        end
        nyumi++;
      end
      sent.push_back(d);
      cyc(1, d, k >= 2, 0, 0, k >= 4);
    end
  endtask

  task automatic test_simul();
    logic [W-1:0] p[4];
    // (a) roll and deq together land one past the old checkpoint
    do_reset(0);
    for (int i = 0; i < 4; i++) begin p[i] = W'($urandom); cyc(1, p[i], 0, 0, 0, 0); end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    checks++; if (v_o !== 1'b1 || data_o !== p[1]) begin errors++; $display("FAIL sim_rolldeq got %h/%b exp %h/1", data_o, v_o, p[1]); end
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (data_o !== p[2]) begin errors++; $display("FAIL sim_rolldeq_next got %h exp %h", data_o, p[2]); end
    // (b) illegal yumi and deq are ignored
    do_reset(0);
    cyc(0, 0, 1, 0, 0, 1);
    checks++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL sim_illegal_empty got v=%b r=%b exp v=0 r=1", v_o, ready_o); end
    cyc(1, p[3], 0, 0, 0, 0);
    checks++; if (v_o !== 1'b1 || data_o !== p[3]) begin errors++; $display("FAIL sim_one got %h/%b exp %h/1", data_o, v_o, p[3]); end
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL sim_issued got %b exp 0", v_o); end
    cyc(0, 0, 0, 0, 1, 0);
    checks++; if (v_o !== 1'b1 || data_o !== p[3]) begin errors++; $display("FAIL sim_illegal_deq got %h/%b exp %h/1", data_o, v_o, p[3]); end
    // (c) reset with traffic pending and inputs active
    do_reset(0);
    for (int i = 0; i < 5; i++) cyc(1, W'(i + 16), 0, 0, 0, 0);
    do_reset(1);
    checks++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL sim_reset got v=%b r=%b exp v=0 r=1", v_o, ready_o); end
  endtask

  task automatic test_random();
    do_reset(0);
    for (int k = 0; k < 500; k++) begin
      logic v, y, c, r, dq;
      logic [W-1:0] d;
      v  = ($urandom_range(0, 99) < 60);
      y  = ($urandom_range(0, 99) < 45);
      dq = ($urandom_range(0, 99) < 35);
      r  = ($urandom_range(0, 99) < 5);
      c  = ($urandom_range(0, 99) < 4);
      d  = W'($urandom);
      cyc(v, d, y, c, r, dq);
      checks++;
      if (v_o !== exp_v() || ready_o !== exp_rdy()) begin
        errors++; $display("FAIL rand_flags_%0d got v=%b r=%b exp v=%b r=%b", k, v_o, ready_o, exp_v(), exp_rdy());
      end
      if (exp_v()) begin
        checks++;
        if (data_o !== exp_d()) begin errors++; $display("FAIL rand_data_%0d got %h exp %h", k, data_o, exp_d()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_replay();
    test_commit_roll();
    test_clr();
    test_wrap();
    test_simul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_be_fe_queue_ckpt.md
Name: bp_be_fe_queue_ckpt

Overview:
- Checkpointing FIFO between the front-end fetch stream and the backend scheduler; buffers fe_queue packets (fetch or exception messages).
- Three pointers: write (wptr), speculative read (rptr), commit checkpoint (cptr).
- Scheduler issue consumes entries with yumi. Commits retire them (deq). Cache-miss replay rewinds to the checkpoint (roll). Pipeline flush drops everything not yet issued (clr).

Parameters:
- width_p, 1, packet width; set to fe_queue_width at instantiation.
- els_p, 8, entry count; must be a power of 2 and at least 2.
- ptr_width_lp, $clog2(els_p)+1, derived; pointer width including a wrap bit.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- data_i  in  width_p  enqueue packet
- v_i  in  1  enqueue valid
- ready_o  out  1  enqueue ready
- data_o  out  width_p  packet at rptr
- v_o  out  1  unread entry available
- yumi_i  in  1  consume the data_o entry; rptr advances
- clr_i  in  1  discard all unread entries
- roll_i  in  1  rewind rptr to cptr
- deq_i  in  1  commit the oldest issued entry; cptr advances

Behaviour:
- Reset: wptr=rptr=cptr=0, so ready_o=1 and v_o=0. Storage is not reset; data_o is don't-care while v_o=0. Reset mid-operation discards all contents within one cycle, regardless of other inputs.
- Pointers are ptr_width_lp wide and wrap modulo 2*els_p. The storage index is the low $clog2(els_p) bits.
- full = (wptr - cptr) == els_p. ready_o = ~full. ready_o depends on registered state only: no same-cycle credit from deq_i or clr_i.
- v_o = (rptr != wptr). data_o = mem[rptr[idx]]. Both are combinational from registered state.
- Enqueue: v_i & ready_o writes mem[wptr] and increments wptr. The entry is visible on v_o the next cycle; there is no bypass.
  - v_i while full is dropped. The source must hold the packet until ready_o is high.
- yumi_i legal only when v_o=1. Effective yumi = yumi_i & v_o; an illegal yumi is ignored.
- deq_i legal only when cptr != rptr (at least one issued, uncommitted entry). Effective deq = deq_i & (cptr != rptr); an illegal deq is ignored.
- Next-state order, applied within the same cycle:
  1. cptr_n = cptr + eff_deq
  2. rptr_n = roll_i ? cptr_n : rptr + eff_yumi (roll overrides yumi)
  3. wptr_n = clr_i ? rptr_n : wptr + enq (clr overrides enqueue)
- roll_i & deq_i together: the commit applies first, then the rewind lands on the new checkpoint.
- clr_i & roll_i together: the queue becomes fully empty (wptr=rptr=cptr).
- clr_i never discards issued-but-uncommitted entries; they stay replayable by a later roll_i.
- Invariant: cptr ≤ rptr ≤ wptr in circular distance, and wptr - cptr ≤ els_p. The verification bench asserts this every cycle.
- Latency: enqueue to v_o is 1 cycle. Roll to replayed data_o is 1 cycle. Clr to v_o=0 is 1 cycle.

Test Plan:
- Fill: els_p=8, enqueue packets 0..7 with no yumi → ready_o falls the cycle after the 8th write. A 9th v_i pulse is dropped. v_o=1 with data_o=0.
- Replay: with 0..7 queued, yumi 3 times (outputs 0,1,2), then roll_i → next cycle data_o=0. Yumi sequence replays 0,1,2,3.
- Commit then roll: yumi 0,1,2; deq_i twice; roll_i → data_o=2. After cptr advanced by 2, ready_o rises and two new enqueues succeed.
- Clr: entries 0..5 queued, yumi 0,1, clr_i → v_o=0 next cycle. roll_i → data_o=0 (issued entries survive); yumi twice gives 0,1, then v_o=0. A same-cycle enqueue with clr is discarded.
- Wrap-around: stream 40 packets with yumi+deq every cycle after a 2-entry lag → output order matches input order across pointer wrap. ready_o never falls. The invariant assertion holds.
- Simultaneous and illegal, plus reset: (a) roll_i+deq_i together → rptr=cptr+1. (b) yumi_i with v_o=0 and deq_i with cptr==rptr → no pointer change. (c) reset_i asserted with 5 entries queued → next cycle v_o=0, ready_o=1.
